if_fetch_queue: RTL and testbench

//  Parametrised instruction-fetch stage with a decoupling fetch queue. Owns the fetch PC and issues

---
 rtl/if_fetch_queue.sv | 115 +++++++++++
 tb/tb_if_fetch_queue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues 1-cycle IMEM reads and queues {pc, inst} for ID.
// Request to head visibility is 2 cycles; ID backpressure via id_ready_i throttles issue so the queue never overflows.
module if_fetch_queue #(
    parameter int                  PC_WIDTH   = 32,
    parameter int                  INST_WIDTH = 32,
    parameter int                  FQ_DEPTH   = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          redirect_valid_i,
    input  logic [PC_WIDTH-1:0]           redirect_pc_i,
    output logic                          imem_req_o,
    output logic [PC_WIDTH-1:0]           imem_addr_o,
    input  logic [INST_WIDTH-1:0]         imem_rdata_i,
    output logic                          id_valid_o,
    input  logic                          id_ready_i,
    output logic [PC_WIDTH-1:0]           id_pc_o,
    output logic [PC_WIDTH-1:0]           id_pc_next_o,
    output logic [INST_WIDTH-1:0]         id_inst_o,
    output logic [$clog2(FQ_DEPTH):0]     fq_count_o
);

    localparam int                  PTR_W   = $clog2(FQ_DEPTH);
    localparam int                  CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(FQ_DEPTH);
    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
    } fq_entry_t;

    fq_entry_t           fq_mem_q [FQ_DEPTH];
    fq_entry_t           head;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] inflight_pc_q;
    logic                inflight_q;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    occupancy;
    logic                head_vld;
    logic                pop;
    logic                push;
    logic                req;
    logic                unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    assign head_vld  = (count_q != '0);
    assign pop       = head_vld & id_ready_i;
    // A redirect drops the response landing this cycle; it belongs to the old stream.
    assign push      = inflight_q & ~redirect_valid_i;
    // Count the outstanding read as occupied so its response always has a slot.
    assign occupancy = count_q + CNT_W'(inflight_q) - CNT_W'(pop);
    assign req       = reset_n & ~redirect_valid_i & (occupancy < DEPTH_C);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid_i) begin
            fetch_pc_d = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (req)  fetch_pc_d = fetch_pc_q + PC_STEP;
            if (pop)  rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            if (push) wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= req;
            if (req) inflight_pc_q <= fetch_pc_q;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fq_mem_q[wr_ptr_q] <= {inflight_pc_q, imem_rdata_i};
    end

    assign head         = fq_mem_q[rd_ptr_q];
    assign imem_req_o   = req;
    assign imem_addr_o  = fetch_pc_q;
    assign id_valid_o   = head_vld;
    assign id_pc_o      = head_vld ? head.pc : '0;
    assign id_pc_next_o = head_vld ? head.pc + PC_STEP : '0;
    assign id_inst_o    = head_vld ? head.inst : '0;
    assign fq_count_o   = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && count_q == DEPTH_C));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-level reference model checked every cycle plus directed literal checks.
module tb_if_fetch_queue;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] imem_rdata_i = '0;
    logic        id_ready_i = 1'b0;

    logic        imem_req_o, id_valid_o;
    logic [31:0] imem_addr_o, id_pc_o, id_pc_next_o, id_inst_o;
    logic [2:0]  fq_count_o;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_pc, w_pc_next, w_inst;
    logic [2:0]  w_count;

    if_fetch_queue #(.PC_WIDTH(32), .INST_WIDTH(32), .FQ_DEPTH(D), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
        .id_pc_o(id_pc_o), .id_pc_next_o(id_pc_next_o), .id_inst_o(id_inst_o),
        .fq_count_o(fq_count_o));

    if_fetch_queue #(.PC_WIDTH(32), .INST_WIDTH(32), .FQ_DEPTH(D), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .reset_n(reset_n),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_rdata_i(imem_rdata_i),
        .id_valid_o(w_valid), .id_ready_i(id_ready_i),
        .id_pc_o(w_pc), .id_pc_next_o(w_pc_next), .id_inst_o(w_inst),
        .fq_count_o(w_count));

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Reference model: ordered list of fetched entries plus the one outstanding read.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc = '0;
    bit          m_pend = 0;
    logic [31:0] m_pend_pc = '0;
    bit          last_req = 0;
    logic [31:0] last_addr = '0;

    always @(negedge clk) begin : cmp
        bit   pop;
        bit   ereq;
        int   occ;
        ent_t e;
        if (!reset_n) begin
            chk("rst_req",   imem_req_o, 0);
            chk("rst_valid", id_valid_o, 0);
            chk("rst_count", fq_count_o, 0);
            chk("rst_pc",    id_pc_o, 0);
            chk("rst_inst",  id_inst_o, 0);
            mq.delete();
            m_pc     = 32'h0;
            m_pend   = 0;
            last_req = 0;
        end else begin
            pop  = (mq.size() != 0) && id_ready_i;
            occ  = mq.size() + int'(m_pend) - int'(pop);
            ereq = !redirect_valid_i && (occ < D);
            chk("m_req",   imem_req_o, ereq);
            chk("m_addr",  imem_addr_o, m_pc);
            chk("m_valid", id_valid_o, mq.size() != 0);
            chk("m_count", fq_count_o, mq.size());
            if (mq.size() != 0) begin
                chk("m_pc",      id_pc_o, mq[0].pc);
                chk("m_pc_next", id_pc_next_o, mq[0].pc + 32'd4);
                chk("m_inst",    id_inst_o, mq[0].inst);
            end else begin
                chk("m_pc_empty",   id_pc_o, 0);
                chk("m_next_empty", id_pc_next_o, 0);
                chk("m_inst_empty", id_inst_o, 0);
            end
            last_req  = imem_req_o;
            last_addr = imem_addr_o;
            if (pop) void'(mq.pop_front());
            if (redirect_valid_i) begin
                mq.delete();
                m_pend = 0;
                m_pc   = {redirect_pc_i[31:2], 2'b00};
            end else begin
                if (m_pend) begin
                    e.pc   = m_pend_pc;
                    e.inst = inst_of(m_pend_pc);
                    mq.push_back(e);
                end
                m_pend    = ereq;
                m_pend_pc = m_pc;
                if (ereq) m_pc = m_pc + 32'd4;
            end
        end
    end

    // IMEM: answers the previous cycle's request, garbage otherwise.
    initial forever begin
        @(posedge clk);
        #1;
        imem_rdata_i = last_req ? inst_of(last_addr) : $urandom;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    int nreq;

    initial begin
        step(); step();
        // Reset release, free-flowing drain.
        id_ready_i = 1'b1;
        reset_n    = 1'b1;
        settle();
        chk("t1_c0_req", imem_req_o, 1);
        chk("t1_c0_addr", imem_addr_o, 32'h0);
        chk("t1_c0_valid", id_valid_o, 0);
        chk("t5_c0_addr", w_addr, 32'hFFFF_FFF8);
        step(); settle();
        chk("t1_c1_addr", imem_addr_o, 32'h4);
        chk("t1_c1_valid", id_valid_o, 0);
        chk("t5_c1_addr", w_addr, 32'hFFFF_FFFC);
        step(); settle();
        chk("t1_c2_valid", id_valid_o, 1);
        chk("t1_c2_pc", id_pc_o, 32'h0);
        chk("t1_c2_pc_next", id_pc_next_o, 32'h4);
        chk("t1_c2_inst", id_inst_o, 32'hC0DE_0000);
        chk("t5_c2_addr", w_addr, 32'h0);
        chk("t5_c2_pc", w_pc, 32'hFFFF_FFF8);
        step(); settle();
        chk("t1_c3_pc", id_pc_o, 32'h4);
        chk("t5_c3_pc", w_pc, 32'hFFFF_FFFC);
        chk("t5_c3_pc_next", w_pc_next, 32'h0);
        step(); settle();
        chk("t1_c4_pc", id_pc_o, 32'h8);
        repeat (3) step();

        // Stall from reset: fetch fills the queue and stops.
        reset_n    = 1'b0;
        id_ready_i = 1'b0;
        step();
        reset_n = 1'b1;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            settle();
            nreq += int'(imem_req_o);
            step();
        end
        chk("t2_reqs", nreq, 4);
        settle();
        chk("t2_count", fq_count_o, 4);
        chk("t2_req_off", imem_req_o, 0);
        chk("t2_head_pc", id_pc_o, 32'h0);
        id_ready_i = 1'b1;
        nreq = 0;
        settle();
        nreq += int'(imem_req_o);
        step();
        id_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            nreq += int'(imem_req_o);
            step();
        end
        chk("t2_reqs_after_pop", nreq, 1);
        settle();
        chk("t2_head_after_pop", id_pc_o, 32'h4);

        // Redirect with 3 queued and one read in flight.
        id_ready_i = 1'b1;
        step();
        id_ready_i       = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h100;
        settle();
        chk("t3_T_count", fq_count_o, 3);
        chk("t3_T_req", imem_req_o, 0);
        step();
        redirect_valid_i = 1'b0;
        settle();
        chk("t3_T1_count", fq_count_o, 0);
        chk("t3_T1_valid", id_valid_o, 0);
        chk("t3_T1_addr", imem_addr_o, 32'h100);
        chk("t3_T1_req", imem_req_o, 1);
        step(); settle();
        chk("t3_T2_valid", id_valid_o, 0);
        step(); settle();
        chk("t3_T3_valid", id_valid_o, 1);
        chk("t3_T3_pc", id_pc_o, 32'h100);
        chk("t3_T3_inst", id_inst_o, 32'hC0DE_0100);
        repeat (4) step();

        // Push, pop and redirect in one cycle, unaligned target.
        id_ready_i = 1'b1;
        step(); step();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h103;
        settle();
        chk("t4_T_valid", id_valid_o, 1);
        chk("t4_T_count", fq_count_o, 3);
        chk("t4_T_req", imem_req_o, 0);
        step();
        redirect_valid_i = 1'b0;
        settle();
        chk("t4_T1_count", fq_count_o, 0);
        chk("t4_T1_addr", imem_addr_o, 32'h100);
        step(); step(); settle();
        chk("t4_T3_pc", id_pc_o, 32'h100);

        // Back-to-back redirects: last wins.
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h200;
        step();
        redirect_pc_i = 32'h300;
        step();
        redirect_valid_i = 1'b0;
        settle();
        chk("t4b_addr", imem_addr_o, 32'h300);
        step(); step(); settle();
        chk("t4b_pc", id_pc_o, 32'h300);

        // Reset mid-stream with a full queue.
        id_ready_i = 1'b0;
        repeat (6) step();
        settle();
        chk("t6_pre_count", fq_count_o, 4);
        reset_n = 1'b0;
        settle();
        chk("t6_valid", id_valid_o, 0);
        chk("t6_req", imem_req_o, 0);
        chk("t6_count", fq_count_o, 0);
        step(); step();
        reset_n = 1'b1;
        settle();
        chk("t6_restart_addr", imem_addr_o, 32'h0);
        chk("t6_restart_req", imem_req_o, 1);
        id_ready_i = 1'b1;
        step(); step(); settle();
        chk("t6_restart_valid", id_valid_o, 1);
        chk("t6_restart_pc", id_pc_o, 32'h0);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
